// File: rtl/window3x3_linebuf_rv.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_linebuf_rv
// Purpose  : Raster stream to packed 3x3 window generator with two line buffers.
// Revision : 1.0 - initial release
// ============================================================================
module window3x3_linebuf_rv #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 640,
    parameter int COL_WIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COL_WIDTH-1:0]    img_width,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic [9*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [2:0]              m_axis_tuser,
    output logic                    err
);

    localparam logic [COL_WIDTH-1:0] C_ONE   = COL_WIDTH'(1);
    localparam logic [COL_WIDTH-1:0] C_TWO   = COL_WIDTH'(2);
    localparam logic [COL_WIDTH-1:0] C_MIN_W = COL_WIDTH'(3);
    localparam logic [COL_WIDTH-1:0] C_MAX_W = COL_WIDTH'(MAX_WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state_q;
    logic [COL_WIDTH-1:0]    w_q;
    logic [COL_WIDTH-1:0]    col_q;
    logic [COL_WIDTH-1:0]    row_q;
    logic                    err_q;
    logic [9*DATA_WIDTH-1:0] m_tdata_q;
    logic                    m_tvalid_q;
    logic                    m_tlast_q;
    logic [2:0]              m_tuser_q;

    logic [DATA_WIDTH-1:0]   lb0_q [MAX_WIDTH];
    logic [DATA_WIDTH-1:0]   lb1_q [MAX_WIDTH];
    logic [DATA_WIDTH-1:0]   col0_q [3];
    logic [DATA_WIDTH-1:0]   col1_q [3];
    logic [DATA_WIDTH-1:0]   w_new [3];
    logic [9*DATA_WIDTH-1:0] w_win;

    logic                    w_accept;
    logic                    w_sof;
    logic                    w_width_ok;
    logic                    w_proc;
    logic [COL_WIDTH-1:0]    w_col;
    logic [COL_WIDTH-1:0]    w_row;
    logic [COL_WIDTH-1:0]    w_w;
    logic                    w_last_col;
    logic                    w_wrap;
    logic                    w_emit;

    assign s_axis_tready = !m_tvalid_q || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_sof         = w_accept && s_axis_tuser;
    assign w_width_ok    = (img_width >= C_MIN_W) && (img_width <= C_MAX_W);
    // An SOF beat is itself pixel (0,0) of the new frame, in either state.
    assign w_proc        = w_accept && (s_axis_tuser ? w_width_ok : (state_q == ST_ACTIVE));
    assign w_col         = s_axis_tuser ? '0 : col_q;
    assign w_row         = s_axis_tuser ? '0 : row_q;
    assign w_w           = s_axis_tuser ? img_width : w_q;
    assign w_last_col    = (w_col == (w_w - C_ONE));
    assign w_wrap        = w_last_col || s_axis_tlast;
    assign w_emit        = w_proc && (w_row >= C_TWO) && (w_col >= C_TWO);

    always_comb begin
        w_new[0] = lb1_q[w_col];
        w_new[1] = lb0_q[w_col];
        w_new[2] = s_axis_tdata;
        w_win    = '0;
        for (int r = 0; r < 3; r++) begin
            w_win[DATA_WIDTH*(r*3)   +: DATA_WIDTH] = col0_q[r];
            w_win[DATA_WIDTH*(r*3+1) +: DATA_WIDTH] = col1_q[r];
            w_win[DATA_WIDTH*(r*3+2) +: DATA_WIDTH] = w_new[r];
        end
    end

    always_ff @(posedge clk) begin
        if (w_proc) begin
            lb1_q[w_col] <= w_new[1];
            lb0_q[w_col] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            err_q      <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
            for (int r = 0; r < 3; r++) begin
                col0_q[r] <= '0;
                col1_q[r] <= '0;
            end
        end else begin
            if (w_proc) begin
                state_q <= ST_ACTIVE;
                w_q     <= w_w;
                col0_q  <= col1_q;
                col1_q  <= w_new;
                col_q   <= w_wrap ? '0 : (w_col + C_ONE);
                if (w_wrap && !(&w_row)) begin
                    row_q <= w_row + C_ONE;
                end else begin
                    row_q <= w_row;
                end
                err_q <= (s_axis_tuser ? 1'b0 : err_q) | (s_axis_tlast != w_last_col);
            end else if (w_sof) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
            end

            if (w_emit) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= w_win;
                m_tlast_q  <= w_last_col;
                m_tuser_q  <= {2'b00, (w_row == C_TWO) && (w_col == C_TWO)};
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;
    assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_window3x3_linebuf_rv.sv
`default_nettype none
// ============================================================================
// Module   : tb_window3x3_linebuf_rv
// Purpose  : Directed self-checking bench for the 3x3 window line-buffer block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window3x3_linebuf_rv;

    localparam logic [71:0] C_FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  img_width = 10'd5;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [71:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [2:0]  m_axis_tuser;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [71:0] win_data [64];
    logic        win_last [64];
    logic [2:0]  win_user [64];
    int          n_win = 0;
    int          base = 0;
    bit          toggle = 1'b0;
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    logic [71:0] prev_data;
    logic        prev_last;
    logic [2:0]  prev_user;

    always #5 clk = ~clk;

    window3x3_linebuf_rv #(
        .DATA_WIDTH(8),
        .MAX_WIDTH (640),
        .COL_WIDTH (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .img_width    (img_width),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int i);
        int r = 2 + i / 3;
        int c = 2 + i % 3;
        logic [71:0] v = '0;
        for (int k = 0; k < 9; k++) begin
            v[8*k +: 8] = 8'((r - 2 + k / 3) * 16 + (c - 2 + k % 3));
        end
        return v;
    endfunction

    // Called once per cycle at the falling edge: handshake rules and window capture.
    task automatic observe();
        chk("s_tready_rule", 72'(s_axis_tready), 72'(!m_axis_tvalid || m_axis_tready));
        if (prev_stall) begin
            chk("stall_tdata", m_axis_tdata, prev_data);
            chk("stall_tlast", 72'(m_axis_tlast), 72'(prev_last));
            chk("stall_tuser", 72'(m_axis_tuser), 72'(prev_user));
        end
        if (m_axis_tvalid && m_axis_tready && n_win < 64) begin
            win_data[n_win] = m_axis_tdata;
            win_last[n_win] = m_axis_tlast;
            win_user[n_win] = m_axis_tuser;
            n_win++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        prev_user  = m_axis_tuser;
    endtask

    task automatic next_ready();
        cyc++;
        m_axis_tready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    endtask

    task automatic step_cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        next_ready();
    endtask

    task automatic drain(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        bit got = 1'b0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            observe();
            got = s_axis_tready;
            @(posedge clk);
            #1;
            next_ready();
        end
        if (!got) chk("send_timeout", 72'(1), 72'(0));
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit lat);
        img_width = 10'd5;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                send(8'(r * 16 + c), (r == 0 && c == 0), (c == 4));
                if (r == 0 && c == 0) chk("sof_clears_err", 72'(err), 72'(0));
                if (lat && r == 2 && c == 2) begin
                    chk("latency_valid", 72'(m_axis_tvalid), 72'(1));
                    chk("latency_tdata", m_axis_tdata, C_FIRST_WIN);
                end
            end
        end
    endtask

    task automatic check_frame(input string tag);
        drain(10);
        chk({tag, "_count"}, 72'(n_win - base), 72'(6));
        for (int i = 0; i < 6 && base + i < 64; i++) begin
            chk({tag, "_tdata"}, win_data[base+i], exp_win(i));
            chk({tag, "_tlast"}, 72'(win_last[base+i]), 72'(i % 3 == 2));
            chk({tag, "_tuser"}, 72'(win_user[base+i]), 72'(i == 0));
        end
        chk({tag, "_first_const"}, win_data[base], C_FIRST_WIN);
        chk({tag, "_err"}, 72'(err), 72'(0));
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_tvalid", 72'(m_axis_tvalid), 72'(0));
        chk("rst_tdata", m_axis_tdata, 72'(0));
        chk("rst_tlast", 72'(m_axis_tlast), 72'(0));
        chk("rst_tuser", 72'(m_axis_tuser), 72'(0));
        chk("rst_err", 72'(err), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Beats without SOF in IDLE are dropped, then a normal frame
        base = n_win;
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        send(8'hA3, 1'b1 ^ 1'b1, 1'b1);
        drain(3);
        chk("pre_sof_no_output", 72'(n_win - base), 72'(0));
        send_frame(1'b1);
        check_frame("frame1");

        // Same frame under 1,0,0,1 backpressure
        toggle = 1'b1;
        base = n_win;
        send_frame(1'b0);
        check_frame("stall");
        toggle = 1'b0;
        drain(4);

        // Early tlast at row 1 col 2: error, row advances to 2
        img_width = 10'd5;
        for (int c = 0; c < 5; c++) send(8'(c), (c == 0), (c == 4));
        send(8'h10, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b1);
        chk("early_tlast_err", 72'(err), 72'(1));
        base = n_win;
        send(8'h20, 1'b0, 1'b0);
        send(8'h21, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        drain(4);
        chk("row_adv_count", 72'(n_win - base), 72'(1));
        chk("row_adv_tdata", win_data[base], C_FIRST_WIN);
        chk("row_adv_tuser", 72'(win_user[base]), 72'(1));
        chk("row_adv_tlast", 72'(win_last[base]), 72'(0));
        chk("err_sticky", 72'(err), 72'(1));
        base = n_win;
        send_frame(1'b0);
        check_frame("resync");

        // Out-of-range width on SOF: error, back to IDLE, beats dropped
        base = n_win;
        img_width = 10'd2;
        send(8'h00, 1'b1, 1'b0);
        chk("bad_width_err", 72'(err), 72'(1));
        img_width = 10'd5;
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b1);
        drain(4);
        chk("bad_width_no_output", 72'(n_win - base), 72'(0));
        chk("bad_width_err_hold", 72'(err), 72'(1));
        send_frame(1'b0);
        check_frame("after_bad");

        // Asynchronous reset after 12 pixels
        img_width = 10'd5;
        for (int i = 0; i < 12; i++) send(8'((i / 5) * 16 + i % 5), (i == 0), (i % 5 == 4));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 72'(m_axis_tvalid), 72'(0));
        chk("arst_tdata", m_axis_tdata, 72'(0));
        chk("arst_tlast", 72'(m_axis_tlast), 72'(0));
        chk("arst_tuser", 72'(m_axis_tuser), 72'(0));
        chk("arst_err", 72'(err), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prev_stall = 1'b0;
        base = n_win;
        send_frame(1'b1);
        check_frame("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
